// File: rtl/mips_isa_pkg.sv
// MIPS opcode/funct constants shared with the CPU decode, the programmer's mnemonic codes and FSM states.
// VRD/VCMP states exist only when IMEM_VERIFY_EN is defined.
package mips_isa_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        MN_ADD     = 4'd0,
        MN_SUB     = 4'd1,
        MN_AND     = 4'd2,
        MN_OR      = 4'd3,
        MN_SLT     = 4'd4,
        MN_JR      = 4'd5,
        MN_BEQ     = 4'd6,
        MN_BNE     = 4'd7,
        MN_J       = 4'd8,
        MN_JAL     = 4'd9,
        MN_SLTI    = 4'd10,
        MN_LW      = 4'd11,
        MN_SW      = 4'd12,
        MN_ADDI    = 4'd13,
        MN_ADDIU   = 4'd14,
        MN_ILLEGAL = 4'd15
    } mnem_t;

`ifdef IMEM_VERIFY_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_WRITE, ST_VRD, ST_VCMP, ST_FULL
    } prog_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_WRITE, ST_FULL
    } prog_state_t;
`endif

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OPC_RTYPE, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational packing of symbolic instruction fields into a 32-bit MIPS word.
module instr_encoder
    import mips_isa_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    mnem_t w_mn;
    assign w_mn = mnem_t'(i_op);

    always_comb begin
        o_word    = 32'h0;
        o_illegal = 1'b0;
        case (w_mn)
            MN_ADD:   o_word = enc_r(i_rs, i_rt, i_rd, FN_ADD);
            MN_SUB:   o_word = enc_r(i_rs, i_rt, i_rd, FN_SUB);
            MN_AND:   o_word = enc_r(i_rs, i_rt, i_rd, FN_AND);
            MN_OR:    o_word = enc_r(i_rs, i_rt, i_rd, FN_OR);
            MN_SLT:   o_word = enc_r(i_rs, i_rt, i_rd, FN_SLT);
            // jr only carries rs; rt/rd fields are forced to zero
            MN_JR:    o_word = enc_r(i_rs, 5'd0, 5'd0, FN_JR);
            MN_BEQ:   o_word = enc_i(OPC_BEQ, i_rs, i_rt, i_imm);
            MN_BNE:   o_word = enc_i(OPC_BNE, i_rs, i_rt, i_imm);
            MN_J:     o_word = {OPC_J, i_target};
            MN_JAL:   o_word = {OPC_JAL, i_target};
            MN_SLTI:  o_word = enc_i(OPC_SLTI, i_rs, i_rt, i_imm);
            MN_LW:    o_word = enc_i(OPC_LW, i_rs, i_rt, i_imm);
            MN_SW:    o_word = enc_i(OPC_SW, i_rs, i_rt, i_imm);
            MN_ADDI:  o_word = enc_i(OPC_ADDI, i_rs, i_rt, i_imm);
            MN_ADDIU: o_word = enc_i(OPC_ADDIU, i_rs, i_rt, i_imm);
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imem_programmer.sv
// Instruction-memory programmer: encodes fields, writes sequential words, holds the CPU in reset meanwhile.
// Optional readback check enabled by IMEM_VERIFY_EN.
module imem_programmer
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       imem_rdata,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W:0] CAP    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CAP_M1 = {1'b0, {ADDR_W{1'b1}}};

    prog_state_t       r_state, w_next;
    logic [ADDR_W:0]   r_count, w_cnt_nxt;
    logic [31:0]       r_wdata;
    logic              r_we, r_hold, r_full, r_err;
    logic [ADDR_W-1:0] r_addr;

    logic [31:0] w_enc_word;
    logic        w_enc_illegal;
    logic        w_ready, w_accept, w_ctrl_state, w_sess_start, w_sess_end;
    logic        w_inc, w_mismatch;

    instr_encoder u_enc (
        .i_op     (in_op),
        .i_rs     (in_rs),
        .i_rt     (in_rt),
        .i_rd     (in_rd),
        .i_imm    (in_imm),
        .i_target (in_target),
        .o_word   (w_enc_word),
        .o_illegal(w_enc_illegal)
    );

    assign w_ready      = (r_state == ST_LOAD) & ~start & ~finish;
    assign w_accept     = in_valid & w_ready;
    assign w_ctrl_state = (r_state == ST_IDLE) | (r_state == ST_LOAD) | (r_state == ST_FULL);
    assign w_sess_start = start & w_ctrl_state;
    assign w_sess_end   = finish & ~start & ((r_state == ST_LOAD) | (r_state == ST_FULL));

`ifdef IMEM_VERIFY_EN
    assign w_inc      = (r_state == ST_VCMP) & (imem_rdata == r_wdata);
    assign w_mismatch = (r_state == ST_VCMP) & (imem_rdata != r_wdata);
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^imem_rdata;
    assign w_inc      = (r_state == ST_WRITE);
    assign w_mismatch = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_LOAD;
            ST_LOAD: begin
                if (start)
                    w_next = ST_LOAD;
                else if (finish)
                    w_next = ST_IDLE;
                else if (w_accept & ~w_enc_illegal)
                    w_next = ST_WRITE;
            end
`ifdef IMEM_VERIFY_EN
            ST_WRITE: w_next = ST_VRD;
            ST_VRD:   w_next = ST_VCMP;
            ST_VCMP: begin
                if (w_mismatch)
                    w_next = ST_LOAD;
                else
                    w_next = (r_count == CAP_M1) ? ST_FULL : ST_LOAD;
            end
`else
            ST_WRITE: w_next = (r_count == CAP_M1) ? ST_FULL : ST_LOAD;
`endif
            ST_FULL: begin
                if (start)
                    w_next = ST_LOAD;
                else if (finish)
                    w_next = ST_IDLE;
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    // Counter saturates at capacity; address output tracks the next count so it is registered
    always_comb begin
        w_cnt_nxt = r_count;
        if (w_sess_start)
            w_cnt_nxt = '0;
        else if (w_inc && (r_count != CAP))
            w_cnt_nxt = r_count + {{ADDR_W{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_hold  <= 1'b0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_count <= w_cnt_nxt;
            r_addr  <= w_cnt_nxt[ADDR_W-1:0];
            r_we    <= (w_next == ST_WRITE);
            r_hold  <= (w_next != ST_IDLE);
            r_full  <= (w_next == ST_FULL);
            if (w_accept && !w_enc_illegal)
                r_wdata <= w_enc_word;
            if (w_sess_start)
                r_err <= 1'b0;
            else if ((w_accept && w_enc_illegal) || w_mismatch)
                r_err <= 1'b1;
        end
    end

    assign in_ready   = w_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_hold   = r_hold;
    assign word_count = r_count;
    assign full       = r_full;
    assign err        = r_err;

    logic w_unused_end;
    assign w_unused_end = w_sess_end;

endmodule
